// File: rtl/main_mem_ws.sv
// ---------------------------------------------------------------------------
// main_mem_ws
//   Single-port main memory with a request/ready handshake, programmable wait
//   states, byte-lane write strobes and out-of-range error reporting.
//
//   Parameters
//     DATA_W       data width in bits (multiple of 8)
//     ADDR_W       word address width
//     DEPTH        number of words (<= 2**ADDR_W, any value)
//     WAIT_CYCLES  extra wait cycles before each access (0..15)
//
//   Ports
//     clk             system clock, rising edge
//     rst_n           asynchronous active-low reset
//     ce              chip enable, qualifies rden/wren
//     rden, wren      read / write request (read wins if both high)
//     addr            word address
//     wr_instruction  write data
//     be              byte-lane write enables, bit i -> bits [8i+7:8i]
//     rd_instruction  read data, held until the next read completes
//     cpu_ready       one-cycle completion pulse for reads and writes
//     busy            request in progress; new requests are dropped
//     err             one-cycle pulse with cpu_ready when addr >= DEPTH
// ---------------------------------------------------------------------------
module main_mem_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  rden,
  input  logic                  wren,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wr_instruction,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rd_instruction,
  output logic                  cpu_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range limit one bit wider than the address so DEPTH == 2**ADDR_W fits.
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              access;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_rd;
  logic              acc_ok;
  logic [IDX_W-1:0]  acc_idx;
  logic              addr_q_ok;

  assign accept = (state == S_IDLE) && ce && (rden || wren);

  // With zero wait states the access happens on the accept edge itself, so
  // the operands come straight from the ports instead of the latched copies.
  always_comb begin
    if (state == S_IDLE) begin
      acc_addr  = addr;
      acc_wdata = wr_instruction;
      acc_be    = be;
      acc_rd    = rden;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      acc_rd    = rd_q;
    end
  end

  assign acc_ok    = {1'b0, acc_addr} < DEPTH_L;
  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign addr_q_ok = {1'b0, addr_q} < DEPTH_L;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    access     = 1'b0;
    busy       = 1'b0;
    cpu_ready  = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            access     = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        busy       = 1'b1;
        cpu_ready  = 1'b1;
        err        = !addr_q_ok;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wr_instruction;
        be_q    <= be;
        rd_q    <= rden;
        cnt     <= CNT_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Read data only changes on a read access; writes leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_instruction <= '0;
    end else if (access && acc_rd) begin
      rd_instruction <= acc_ok ? mem[acc_idx] : '0;
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst_n and a
  // reset would also prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (access && !acc_rd && acc_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_main_mem_ws.sv
// ---------------------------------------------------------------------------
// tb_main_mem_ws
//   Directed self-checking bench. Two instances share the clock, reset and
//   request buses: u0 (WAIT_CYCLES=0, DEPTH=4096) and u3 (WAIT_CYCLES=3,
//   DEPTH=3000); each has its own chip enable.
// ---------------------------------------------------------------------------
module tb_main_mem_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce0, ce3, rden, wren;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [31:0] rd0, rd3;
  logic        rdy0, rdy3, busy0, busy3, err0, err3;

  int          sel;
  logic        rdy_s, busy_s, err_s;
  logic [31:0] rd_s;

  int          n_chk = 0;
  int          n_err = 0;

  int          lat_o, bcnt_o;
  logic        err_o;
  logic [31:0] rd_o;

  always #5 clk = ~clk;

  main_mem_ws #(.DATA_W(32), .ADDR_W(12), .DEPTH(4096), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce0), .rden(rden), .wren(wren),
    .addr(addr), .wr_instruction(wdata), .be(be),
    .rd_instruction(rd0), .cpu_ready(rdy0), .busy(busy0), .err(err0)
  );

  main_mem_ws #(.DATA_W(32), .ADDR_W(12), .DEPTH(3000), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ce(ce3), .rden(rden), .wren(wren),
    .addr(addr), .wr_instruction(wdata), .be(be),
    .rd_instruction(rd3), .cpu_ready(rdy3), .busy(busy3), .err(err3)
  );

  assign rdy_s  = (sel == 3) ? rdy3  : rdy0;
  assign busy_s = (sel == 3) ? busy3 : busy0;
  assign err_s  = (sel == 3) ? err3  : err0;
  assign rd_s   = (sel == 3) ? rd3   : rd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a request at a negedge; the following posedge is E0.
  task automatic issue(input int s, input logic r, input logic w,
                       input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    sel   = s;
    addr  = a;
    wdata = d;
    be    = b;
    rden  = r;
    wren  = w;
    if (s == 3) ce3 = 1'b1; else ce0 = 1'b1;
    @(posedge clk);
    #1;
    ce0  = 1'b0;
    ce3  = 1'b0;
    rden = 1'b0;
    wren = 1'b0;
  endtask

  // Count negedges after E0 until cpu_ready; then one more negedge so the
  // selected instance is back in IDLE when the next request goes out.
  task automatic wait_ready();
    lat_o  = 0;
    bcnt_o = 0;
    err_o  = 1'b0;
    rd_o   = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy_s) bcnt_o++;
      if (rdy_s) begin
        lat_o = i;
        err_o = err_s;
        rd_o  = rd_s;
        break;
      end
    end
    check("ready_seen", {31'b0, lat_o != 0}, 32'd1);
    @(negedge clk);
    check("ready_one_cycle", {30'b0, rdy_s, busy_s}, 32'd0);
    ce0  = 1'b0;
    ce3  = 1'b0;
    rden = 1'b0;
    wren = 1'b0;
  endtask

  task automatic op(input int s, input logic r, input logic w,
                    input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(s, r, w, a, d, b);
    wait_ready();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b1;
    ce0 = 1'b0; ce3 = 1'b0; rden = 1'b0; wren = 1'b0;
    addr = '0; wdata = '0; be = '0; sel = 0;

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    check("rst_u0_outs", {29'b0, rdy0, busy0, err0}, 32'd0);
    check("rst_u0_rd",   rd0, 32'd0);
    check("rst_u3_outs", {29'b0, rdy3, busy3, err3}, 32'd0);
    check("rst_u3_rd",   rd3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- zero wait states ----
    op(0, 1'b0, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF);
    check("w0_wr_lat",  lat_o, 32'd1);
    check("w0_wr_busy", bcnt_o, 32'd1);
    check("w0_wr_err",  {31'b0, err_o}, 32'd0);
    op(0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
    check("w0_rd_lat",  lat_o, 32'd1);
    check("w0_rd_data", rd_o, 32'hDEADBEEF);

    op(0, 1'b0, 1'b1, 12'h020, 32'hAABBCCDD, 4'hF);
    check("rd_hold_after_wr", rd0, 32'hDEADBEEF);
    op(0, 1'b0, 1'b1, 12'h020, 32'h11223344, 4'b0101);
    op(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
    check("byte_lanes", rd_o, 32'hAA22CC44);

    op(0, 1'b0, 1'b1, 12'h020, 32'h0, 4'h0);
    op(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
    check("be_zero_nochange", rd_o, 32'hAA22CC44);

    // Read and write together: read only.
    op(0, 1'b1, 1'b1, 12'h005, 32'h0, 4'hF);
    check("prio_rd_data", rd_o, 32'hDEADBEEF);
    op(0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
    check("prio_no_write", rd_o, 32'hDEADBEEF);

    // ---- three wait states, DEPTH=3000 ----
    op(3, 1'b0, 1'b1, 12'h010, 32'h12345678, 4'hF);
    check("w3_wr_lat", lat_o, 32'd4);
    op(3, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    check("w3_rd_lat",  lat_o, 32'd4);
    check("w3_rd_busy", bcnt_o, 32'd4);
    check("w3_rd_data", rd_o, 32'h12345678);
    check("w3_rd_err",  {31'b0, err_o}, 32'd0);

    op(3, 1'b0, 1'b1, 12'd2999, 32'h5555AAAA, 4'hF);
    op(3, 1'b0, 1'b1, 12'd3000, 32'hFFFFFFFF, 4'hF);
    check("oor_wr_err", {31'b0, err_o}, 32'd1);
    check("oor_wr_lat", lat_o, 32'd4);
    op(3, 1'b1, 1'b0, 12'd3000, 32'h0, 4'h0);
    check("oor_rd_err",  {31'b0, err_o}, 32'd1);
    check("oor_rd_data", rd_o, 32'd0);
    op(3, 1'b1, 1'b0, 12'd2999, 32'h0, 4'h0);
    check("last_word_data", rd_o, 32'h5555AAAA);
    check("last_word_err",  {31'b0, err_o}, 32'd0);

    // Write request while busy is dropped.
    issue(3, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    ce3   = 1'b1;
    wren  = 1'b1;
    addr  = 12'h010;
    wdata = 32'hBAD0BAD0;
    be    = 4'hF;
    wait_ready();
    check("busy_rd_data", rd_o, 32'h12345678);
    op(3, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    check("dropped_wr", rd_o, 32'h12345678);

    // Reset during the wait phase of a write.
    issue(3, 1'b0, 1'b1, 12'h010, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    check("wait_busy", {31'b0, busy3}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreq_rst_outs", {29'b0, rdy3, busy3, err3}, 32'd0);
    check("midreq_rst_rd0",  rd0, 32'd0);
    check("midreq_rst_rd3",  rd3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy3) seen++;
    end
    check("abandoned_no_ready", seen, 32'd0);
    op(3, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    check("abandoned_no_write", rd_o, 32'h12345678);
    op(0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
    check("mem_kept_over_rst", rd_o, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
